// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter and its helpers.
// Holds the arbiter FSM encoding, RAM state codes and the round-robin pointer step.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } arb_state_t;

  localparam logic [2:0] RAM_STATE_WRITE = 3'b011;
  localparam logic [2:0] RAM_STATE_IDLE  = 3'b000;
  localparam int         RAM_WORD_BYTES  = 8;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Produces a one-hot grant and its encoded index; all-zero grant when nothing is requested.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;
  logic             w_hit;
  logic             w_found;

  // Scan the ring starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_sum   = {1'b0, i_ptr} + (IDX_W+1)'(k);
      w_cand  = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N)) : w_sum[IDX_W-1:0];
      w_hit   = i_req[w_cand] & ~w_found;
      o_grant[w_cand] = o_grant[w_cand] | w_hit;
      o_idx   = w_hit ? w_cand : o_idx;
      w_found = w_found | w_hit;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the single 64-bit read-write port of the RAM.
// One request at a time: IDLE (grant) -> ACCESS (drive RAM) -> RESP (one-cycle pulse).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MEM_SIZE = 524288
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*64-1:0] req_addr,
  input  logic [NUM_REQ*64-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [63:0]           resp_rdata,
  output logic                  resp_error,
  output logic [2:0]            ram_state,
  output logic [63:0]           ram_rw_addr,
  output logic [63:0]           ram_rw_data_in,
  output logic                  ram_rw_write_en,
  input  logic [63:0]           ram_rw_data_out,
  input  logic                  ram_rw_error
);

  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [63:0]        LAST_WORD = 64'(MEM_SIZE - RAM_WORD_BYTES);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_winner;
  logic               r_oor;
  logic [2:0]         r_ram_state;
  logic [63:0]        r_ram_addr;
  logic [63:0]        r_ram_wdata;
  logic               r_ram_we;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [63:0]        r_resp_rdata;
  logic               r_resp_error;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_handshake;
  logic [63:0]        w_sel_addr;
  logic [63:0]        w_sel_wdata;
  logic               w_sel_write;
  logic               w_sel_oor;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Grant is only offered in IDLE and is forced low while reset is held.
  assign w_ready     = (reset_n && (r_state == IDLE)) ? w_grant : '0;
  assign w_handshake = |(w_ready & req_valid);
  assign w_sel_addr  = req_addr[{w_idx, 6'b000000} +: 64];
  assign w_sel_wdata = req_wdata[{w_idx, 6'b000000} +: 64];
  assign w_sel_write = req_write[w_idx];
  assign w_sel_oor   = (w_sel_addr > LAST_WORD);

  // Sequencer FSM; every RAM-side and response output is a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_winner     <= '0;
      r_oor        <= 1'b0;
      r_ram_state  <= RAM_STATE_IDLE;
      r_ram_addr   <= 64'h0;
      r_ram_wdata  <= 64'h0;
      r_ram_we     <= 1'b0;
      r_resp_valid <= '0;
      r_resp_rdata <= 64'h0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_winner   <= w_idx;
            r_oor      <= w_sel_oor;
            r_ram_addr <= w_sel_addr;
            // Out-of-range writes never reach the RAM.
            if (w_sel_write && !w_sel_oor) begin
              r_ram_we    <= 1'b1;
              r_ram_state <= RAM_STATE_WRITE;
              r_ram_wdata <= w_sel_wdata;
            end else begin
              r_ram_we    <= 1'b0;
              r_ram_state <= RAM_STATE_IDLE;
              r_ram_wdata <= 64'h0;
            end
            r_state <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_ram_we     <= 1'b0;
          r_ram_state  <= RAM_STATE_IDLE;
          r_resp_rdata <= ram_rw_data_out;
          r_resp_error <= ram_rw_error | r_oor;
          r_resp_valid <= ONE_HOT0 << r_winner;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= '0;
          r_rr_ptr     <= IDX_W'(rr_next(int'(r_winner), NUM_REQ));
          r_state      <= IDLE;
        end
        default: begin
          r_ram_we     <= 1'b0;
          r_ram_state  <= RAM_STATE_IDLE;
          r_resp_valid <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready       = w_ready;
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_error      = r_resp_error;
  assign ram_state       = r_ram_state;
  assign ram_rw_addr     = r_ram_addr;
  assign ram_rw_data_in  = r_ram_wdata;
  assign ram_rw_write_en = r_ram_we;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a byte-addressed RAM model.
module tb_ram_port_arbiter;

  localparam int          NUM_REQ  = 2;
  localparam int          MEM_SIZE = 524288;
  localparam logic [63:0] LAST     = 64'd524280;

  logic                  clk     = 1'b0;
  logic                  reset_n = 1'b1;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*64-1:0] req_addr;
  logic [NUM_REQ*64-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [63:0]           resp_rdata;
  logic                  resp_error;
  logic [2:0]            ram_state;
  logic [63:0]           ram_rw_addr;
  logic [63:0]           ram_rw_data_in;
  logic                  ram_rw_write_en;
  logic [63:0]           ram_rw_data_out;
  logic                  ram_rw_error;

  int n_checks = 0;
  int n_pass   = 0;
  int we_count = 0;
  bit [7:0] ram_mem [MEM_SIZE];

  logic [63:0]        rd, aa, ad;
  logic               er, aw;
  logic [2:0]         ast;
  logic [NUM_REQ-1:0] rv;
  int                 lat;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_REQ(NUM_REQ), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_state(ram_state), .ram_rw_addr(ram_rw_addr), .ram_rw_data_in(ram_rw_data_in),
    .ram_rw_write_en(ram_rw_write_en), .ram_rw_data_out(ram_rw_data_out), .ram_rw_error(ram_rw_error)
  );

  // RAM model: combinational little-endian read, write commit on the clock edge.
  always_comb begin
    ram_rw_error    = (ram_rw_addr > LAST);
    ram_rw_data_out = 64'h0;
    for (int b = 0; b < 8; b++)
      ram_rw_data_out[8*b +: 8] = ram_rw_error ? 8'h00 : ram_mem[int'(ram_rw_addr[18:0]) + b];
  end

  always @(posedge clk) begin
    if (ram_rw_write_en) we_count <= we_count + 1;
    if (ram_rw_write_en && ram_state == 3'b011 && ram_rw_addr <= LAST)
      for (int b = 0; b < 8; b++) ram_mem[int'(ram_rw_addr[18:0]) + b] <= ram_rw_data_in[8*b +: 8];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] o_rd, output logic o_er, output int o_lat,
                       output logic [NUM_REQ-1:0] o_rv, output logic o_we, output logic [2:0] o_st,
                       output logic [63:0] o_addr, output logic [63:0] o_din);
    int t;
    o_rd = 64'h0; o_er = 1'b0; o_lat = -1; o_rv = '0;
    req_write[idx] = wr;
    req_addr[idx*64 +: 64] = addr;
    req_wdata[idx*64 +: 64] = wd;
    req_valid[idx] = 1'b1;
    #1;
    t = 0;
    while (req_ready[idx] !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    tick();
    req_valid = '0;
    o_we = ram_rw_write_en; o_st = ram_state; o_addr = ram_rw_addr; o_din = ram_rw_data_in;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (resp_valid != '0) begin
        o_lat = c; o_rv = resp_valid; o_rd = resp_rdata; o_er = resp_error;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    #1 reset_n = 1'b0;
    #1;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", req_ready); else n_pass++;
    n_checks++; if (ram_state !== 3'b000) $display("FAIL rst_state: got %b expected 000", ram_state); else n_pass++;
    n_checks++; if (ram_rw_write_en !== 1'b0) $display("FAIL rst_we: got %b expected 0", ram_rw_write_en); else n_pass++;
    n_checks++; if (ram_rw_addr !== 64'h0) $display("FAIL rst_addr: got %h expected 0", ram_rw_addr); else n_pass++;
    n_checks++; if (ram_rw_data_in !== 64'h0) $display("FAIL rst_din: got %h expected 0", ram_rw_data_in); else n_pass++;
    n_checks++; if (resp_valid !== 2'b00) $display("FAIL rst_resp_valid: got %b expected 00", resp_valid); else n_pass++;
    n_checks++; if (resp_rdata !== 64'h0) $display("FAIL rst_rdata: got %h expected 0", resp_rdata); else n_pass++;
    n_checks++; if (resp_error !== 1'b0) $display("FAIL rst_error: got %b expected 0", resp_error); else n_pass++;
    tick(); tick();
    n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready_held: got %b expected 00", req_ready); else n_pass++;
    req_valid = 2'b00;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_idle();
    req_valid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({req_ready, ram_state, ram_rw_write_en} !== 6'b0)
        $display("FAIL idle_cycle%0d: got ready=%b state=%b we=%b expected 00/000/0", c, req_ready, ram_state, ram_rw_write_en);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    issue(0, 1'b1, 64'h100, 64'h1122334455667788, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL wr_error: got %b expected 0", er); else n_pass++;
    n_checks++; if (rv !== 2'b01) $display("FAIL wr_resp_onehot: got %b expected 01", rv); else n_pass++;
    n_checks++; if ({aw, ast} !== 4'b1011) $display("FAIL wr_access_ctrl: got we=%b state=%b expected 1/011", aw, ast); else n_pass++;
    n_checks++; if (aa !== 64'h100) $display("FAIL wr_access_addr: got %h expected 100", aa); else n_pass++;
    n_checks++; if (ad !== 64'h1122334455667788) $display("FAIL wr_access_din: got %h expected 1122334455667788", ad); else n_pass++;
    issue(0, 1'b0, 64'h100, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (rd !== 64'h1122334455667788) $display("FAIL rd_data: got %h expected 1122334455667788", rd); else n_pass++;
    n_checks++; if ({aw, ast} !== 4'b0000) $display("FAIL rd_access_ctrl: got we=%b state=%b expected 0/000", aw, ast); else n_pass++;
    issue(1, 1'b1, 64'h108, 64'hDEADBEEFCAFEF00D, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (rv !== 2'b10) $display("FAIL wr1_resp_onehot: got %b expected 10", rv); else n_pass++;
    n_checks++; if (rd !== 64'h0) $display("FAIL wr1_prior_data: got %h expected 0", rd); else n_pass++;
    issue(0, 1'b0, 64'h108, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (rd !== 64'hDEADBEEFCAFEF00D) $display("FAIL rd_req1_data: got %h expected deadbeefcafef00d", rd); else n_pass++;
    issue(1, 1'b0, 64'h104, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (rd !== 64'hCAFEF00D11223344) $display("FAIL rd_unaligned: got %h expected cafef00d11223344", rd); else n_pass++;
  endtask

  task automatic test_boundary();
    issue(1, 1'b1, LAST, 64'hA5A55A5A0F0FF0F0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (er !== 1'b0) $display("FAIL bnd_wr_error: got %b expected 0", er); else n_pass++;
    n_checks++; if (aw !== 1'b1) $display("FAIL bnd_wr_we: got %b expected 1", aw); else n_pass++;
    issue(0, 1'b0, LAST, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (er !== 1'b0) $display("FAIL bnd_rd_error: got %b expected 0", er); else n_pass++;
    n_checks++; if (rd !== 64'hA5A55A5A0F0FF0F0) $display("FAIL bnd_rd_data: got %h expected a5a55a5a0f0ff0f0", rd); else n_pass++;
  endtask

  task automatic test_out_of_range();
    int wc0;
    wc0 = we_count;
    issue(0, 1'b1, 64'd524281, 64'hFFFFFFFFFFFFFFFF, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (er !== 1'b1) $display("FAIL oor_wr_error: got %b expected 1", er); else n_pass++;
    n_checks++; if ({aw, ast} !== 4'b0000) $display("FAIL oor_wr_ctrl: got we=%b state=%b expected 0/000", aw, ast); else n_pass++;
    n_checks++; if (we_count !== wc0) $display("FAIL oor_we_pulses: got %0d expected %0d", we_count, wc0); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL oor_latency: got %0d expected 2", lat); else n_pass++;
    issue(1, 1'b0, LAST, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (rd !== 64'hA5A55A5A0F0FF0F0) $display("FAIL oor_prior_kept: got %h expected a5a55a5a0f0ff0f0", rd); else n_pass++;
    issue(1, 1'b0, 64'd524288, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (er !== 1'b1) $display("FAIL oor_rd_error: got %b expected 1", er); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] rdy [13];
    logic [NUM_REQ-1:0] rsp [13];
    logic [NUM_REQ-1:0] exp_rdy, exp_rsp;
    reset_n = 1'b0;
    req_valid = 2'b11; req_write = 2'b00;
    req_addr = {64'h8, 64'h0};
    tick();
    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 13; c++) begin
      rdy[c] = req_ready;
      rsp[c] = resp_valid;
      if (c == 12) req_valid = 2'b00;
      tick();
    end
    for (int c = 0; c < 13; c++) begin
      exp_rdy = (c % 3 == 0) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      n_checks++; if (rdy[c] !== exp_rdy) $display("FAIL rr_grant_c%0d: got %b expected %b", c, rdy[c], exp_rdy); else n_pass++;
      n_checks++; if (rsp[c] !== exp_rsp) $display("FAIL rr_resp_c%0d: got %b expected %b", c, rsp[c], exp_rsp); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [NUM_REQ-1:0] seen;
    int t;
    req_write[0] = 1'b1; req_addr[63:0] = 64'h200; req_wdata[63:0] = 64'h5555AAAA5555AAAA;
    req_valid = 2'b01;
    #1;
    t = 0;
    while (req_ready[0] !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    tick();
    req_valid = 2'b00;
    n_checks++; if (ram_rw_write_en !== 1'b1) $display("FAIL mid_we_before: got %b expected 1", ram_rw_write_en); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (ram_rw_write_en !== 1'b0) $display("FAIL mid_we_drop: got %b expected 0", ram_rw_write_en); else n_pass++;
    n_checks++; if (ram_state !== 3'b000) $display("FAIL mid_state: got %b expected 000", ram_state); else n_pass++;
    n_checks++; if (ram_rw_addr !== 64'h0) $display("FAIL mid_addr: got %h expected 0", ram_rw_addr); else n_pass++;
    n_checks++; if (ram_rw_data_in !== 64'h0) $display("FAIL mid_din: got %h expected 0", ram_rw_data_in); else n_pass++;
    n_checks++; if (resp_rdata !== 64'h0) $display("FAIL mid_rdata: got %h expected 0", resp_rdata); else n_pass++;
    seen = resp_valid;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen = seen | resp_valid;
    end
    reset_n = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen = seen | resp_valid;
    end
    n_checks++; if (seen !== 2'b00) $display("FAIL mid_no_resp: got %b expected 00", seen); else n_pass++;
    issue(1, 1'b0, 64'h200, 64'h0, rd, er, lat, rv, aw, ast, aa, ad);
    n_checks++; if (rd !== 64'h0) $display("FAIL mid_no_commit: got %h expected 0", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL mid_rd_error: got %b expected 0", er); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_write_read();
    test_boundary();
    test_out_of_range();
    test_round_robin();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", n_pass, n_checks);
    $fatal(1);
  end

endmodule
